// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dino_pkg
//  Description : Shared types, sizes and the 7-segment encoder used by the
//                score display path (binary score -> BCD -> multiplexed LEDs).
//  Contents    : SCORE_W, BCD_W, DISPLAY_DIGITS, SCORE_MAX_DISPLAY,
//                conv_state_t (converter FSM states), seg7_encode().
//  Revision    : 1.0  initial release
// ============================================================================
package dino_pkg;

   localparam int SCORE_W           = 16;
   localparam int BCD_W             = 20;    // 5 nibbles cover 0..65535
   localparam int DISPLAY_DIGITS    = 4;
   localparam int SCORE_MAX_DISPLAY = 9999;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_t;

   // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes show nothing.
   function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, one bit per cycle.
//                IDLE --start--> SHIFT (16 cycles) --> DONE (1 cycle) --> IDLE
//  Ports       : sys_clk      clock, rising edge
//                rst          synchronous active-high reset
//                start        begin conversion of bin (honoured in IDLE only)
//                bin[15:0]    binary value, sampled with start
//                busy         high in SHIFT and DONE
//                done         one-cycle pulse; bcd is valid while high
//                bcd[19:0]    five BCD nibbles, units in [3:0]
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
   import dino_pkg::*;
(
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output logic               busy,
   output logic               done,
   output logic [BCD_W-1:0]   bcd
);

   conv_state_t        r_state;
   conv_state_t        w_next_state;
   logic [SCORE_W-1:0] r_shift;
   logic [BCD_W-1:0]   r_bcd;
   logic [3:0]         r_cnt;
   logic [BCD_W-1:0]   w_adj;

   // Add-3 correction on every nibble before the shift.
   for (genvar n = 0; n < BCD_W / 4; n++) begin : g_adj
      assign w_adj[4*n +: 4] = (r_bcd[4*n +: 4] >= 4'd5) ? r_bcd[4*n +: 4] + 4'd3
                                                          : r_bcd[4*n +: 4];
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         CONV_IDLE:  if (start) w_next_state = CONV_SHIFT;
         CONV_SHIFT: if (r_cnt == 4'(SCORE_W - 1)) w_next_state = CONV_DONE;
         CONV_DONE:  w_next_state = CONV_IDLE;
         default:    w_next_state = CONV_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= CONV_IDLE;
         r_shift <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            CONV_IDLE: begin
               if (start) begin
                  r_shift <= bin;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            CONV_SHIFT: begin
               {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
               r_cnt            <= r_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != CONV_IDLE);
   assign done = (r_state == CONV_DONE);
   assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
//  Module      : score_display
//  Description : Converts the game score to BCD and scans it onto a 4-digit
//                common-anode 7-segment display with leading-zero blanking,
//                9999 saturation and blinking while game_over is high.
//  Ports       : sys_clk          clock, rising edge
//                rst              synchronous active-high reset
//                score[15:0]      binary score, may change any cycle
//                game_over        high = blink the display
//                seg_n[6:0]       segments {g,f,e,d,c,b,a}, active low
//                an_n[3:0]        digit enables, active low, bit0 = units
//                dp_n             decimal point, active low, held off
//  Revision    : 1.0  initial release
// ============================================================================
module score_display
   import dino_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_SCANS = 64
)(
   input  logic               sys_clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score,
   input  logic               game_over,
   output logic [6:0]         seg_n,
   output logic [3:0]         an_n,
   output logic               dp_n
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int BLK_W = $clog2(BLINK_SCANS + 1);
   localparam int DIG_W = 4 * DISPLAY_DIGITS;

   logic [SCORE_W-1:0] r_last;
   logic               w_start;
   logic               w_busy;
   logic               w_done;
   logic [BCD_W-1:0]   w_bcd;
   logic [DIG_W-1:0]   r_digits;
   logic [DIV_W-1:0]   r_div;
   logic [1:0]         r_idx;
   logic [BLK_W-1:0]   r_blink_cnt;
   logic               r_phase_on;
   logic               w_wrap;
   logic               w_frame_wrap;
   logic [3:0]         w_digit;
   logic               w_blank;
   logic [6:0]         r_seg_n;
   logic [3:0]         r_an_n;
   logic               r_dp_n;

   // A new conversion starts only when the converter is idle, so score
   // changes during a conversion are picked up on the following idle cycle.
   assign w_start = !w_busy && (score != r_last);

   bin2bcd_seq u_bin2bcd (
      .sys_clk (sys_clk),
      .rst     (rst),
      .start   (w_start),
      .bin     (score),
      .busy    (w_busy),
      .done    (w_done),
      .bcd     (w_bcd)
   );

   // last > 9999 exactly when the ten-thousands nibble is non-zero.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_last   <= '0;
         r_digits <= '0;
      end else begin
         if (w_start) r_last <= score;
         if (w_done) begin
            if (w_bcd[BCD_W-1 -: 4] != 4'd0) r_digits <= {DISPLAY_DIGITS{4'd9}};
            else                             r_digits <= w_bcd[DIG_W-1:0];
         end
      end
   end

   assign w_wrap       = (r_div == DIV_W'(SCAN_DIV - 1));
   assign w_frame_wrap = w_wrap && (r_idx == 2'd3);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (w_wrap) begin
         r_div <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst || !game_over) begin
         r_blink_cnt <= '0;
         r_phase_on  <= 1'b1;
      end else if (w_frame_wrap) begin
         if (r_blink_cnt == BLK_W'(BLINK_SCANS - 1)) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
         end
      end
   end

   // Slot i>0 is dark when it and every more significant digit are zero.
   always_comb begin
      w_digit = r_digits[{r_idx, 2'b00} +: 4];
      case (r_idx)
         2'd0:    w_blank = 1'b0;
         2'd1:    w_blank = (r_digits[DIG_W-1:4]  == '0);
         2'd2:    w_blank = (r_digits[DIG_W-1:8]  == '0);
         default: w_blank = (r_digits[DIG_W-1:12] == '0);
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_seg_n <= 7'h7F;
         r_an_n  <= 4'hF;
         r_dp_n  <= 1'b1;
      end else begin
         r_dp_n <= 1'b1;
         if (w_blank || !r_phase_on) begin
            r_seg_n <= 7'h7F;
            r_an_n  <= 4'hF;
         end else begin
            r_seg_n <= seg7_encode(w_digit);
            r_an_n  <= ~(4'b0001 << r_idx);
         end
      end
   end

   assign seg_n = r_seg_n;
   assign an_n  = r_an_n;
   assign dp_n  = r_dp_n;

endmodule
`default_nettype wire
